// File: rtl/camera_pkg.sv
// camera_pkg
//   Shared constants for the camera capture/dump path.
//   - Dump framer FSM state encodings (ST_*)
//   - Byte handshake state encodings (HS_*)
//   - Frame geometry: header length, bytes per SRAM word, SRAM address width
//   - word_byte(): selects one byte of a 32-bit SRAM word, byte 0 = bits [7:0]
package camera_pkg;

  localparam int SRAM_AW        = 18;
  localparam int HDR_LEN        = 5;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_BYTE    = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [1:0] HS_SEND    = 2'd0;
  localparam logic [1:0] HS_WAIT_HI = 2'd1;
  localparam logic [1:0] HS_WAIT_LO = 2'd2;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tx_byte_hs.sv
// tx_byte_hs
//   One-byte handshake towards the RS232C transmitter: SEND -> WAIT_HI -> WAIT_LO.
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     send              : level request; a byte is launched only while idle in SEND
//     data              : byte to launch, latched together with the start pulse
//     rs_tx_status      : transmitter busy flag
//     rs_tx_start       : registered one-cycle start pulse
//     rs_tx_data        : registered byte, held until the next launch
//     sent              : one-cycle strobe in the cycle WAIT_LO sees status low
module tx_byte_hs
  import camera_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       rs_tx_status,
  output logic       rs_tx_start,
  output logic [7:0] rs_tx_data,
  output logic       sent
);

  logic [1:0] hs;

  // Completion is combinational so the parent can advance in the same edge
  // that returns this block to SEND.
  assign sent = (hs == HS_WAIT_LO) && !rs_tx_status;

  // A start pulse is only issued from SEND with the transmitter idle; the
  // following WAIT states guarantee the pulse is never two cycles long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= HS_SEND;
      rs_tx_start <= 1'b0;
      rs_tx_data  <= 8'h00;
    end else begin
      rs_tx_start <= 1'b0;
      case (hs)
        HS_SEND: begin
          if (send && !rs_tx_status) begin
            rs_tx_start <= 1'b1;
            rs_tx_data  <= data;
            hs          <= HS_WAIT_HI;
          end
        end
        HS_WAIT_HI: if (rs_tx_status) hs <= HS_WAIT_LO;
        HS_WAIT_LO: if (!rs_tx_status) hs <= HS_SEND;
        default:    hs <= HS_SEND;
      endcase
    end
  end

endmodule

// File: rtl/dump_framer.sv
// dump_framer
//   Reads SRAM words 0..last_addr and streams them byte-by-byte to the RS232C
//   transmitter, preceded by a sync/length header and optionally followed by
//   a checksum byte (~sum of payload bytes).
//   Build option: define DUMP_FRAMER_CHECKSUM_EN to include the checksum trailer.
//   Ports:
//     clk, reset_n           : clock, asynchronous active-low reset
//     dump_kick / dump_done  : start pulse in, completion pulse out
//     last_addr              : last word address, captured at kick
//     s1_OE, s1_Addr, s1_RD  : SRAM read port (OE active-low)
//     rs_tx_start/data/status: transmitter handshake
//     rest                   : remaining words [17:2] for the 7-seg display
//     busy                   : frame in progress
module dump_framer
  import camera_pkg::*;
#(
  parameter logic [7:0] SYNC0   = 8'hA5,
  parameter logic [7:0] SYNC1   = 8'h5A,
  parameter int         RD_WAIT = 2
)
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dump_kick,
  output logic               dump_done,
  input  logic [SRAM_AW-1:0] last_addr,
  output logic               s1_OE,
  output logic [SRAM_AW-1:0] s1_Addr,
  input  logic [31:0]        s1_RD,
  output logic               rs_tx_start,
  output logic [7:0]         rs_tx_data,
  input  logic               rs_tx_status,
  output logic [15:0]        rest,
  output logic               busy
);

  logic [2:0]         state, state_d;
  logic [2:0]         idx, idx_d;
  logic [2:0]         wcnt, wcnt_d;
  logic [SRAM_AW-1:0] len_q, len_d;
  logic [SRAM_AW-1:0] addr, addr_d;
  logic [31:0]        word_q, word_d;
  logic               send, sent;
  logic [7:0]         byte_c;
`ifdef DUMP_FRAMER_CHECKSUM_EN
  logic [7:0]         sum, sum_d;
`endif

  tx_byte_hs u_hs (
    .clk          (clk),
    .reset_n      (reset_n),
    .send         (send),
    .data         (byte_c),
    .rs_tx_status (rs_tx_status),
    .rs_tx_start  (rs_tx_start),
    .rs_tx_data   (rs_tx_data),
    .sent         (sent)
  );

  // Next-state logic. The first header byte is requested already in the kick
  // cycle so its start pulse lands in the first busy cycle.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    wcnt_d  = wcnt;
    len_d   = len_q;
    addr_d  = addr;
    word_d  = word_q;
    send    = 1'b0;
    byte_c  = SYNC0;
`ifdef DUMP_FRAMER_CHECKSUM_EN
    sum_d   = sum;
`endif
    case (state)
      ST_IDLE: begin
        if (dump_kick) begin
          send    = 1'b1;
          len_d   = last_addr;
          addr_d  = '0;
          idx_d   = 3'd0;
          state_d = ST_HDR;
`ifdef DUMP_FRAMER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      ST_HDR: begin
        send = 1'b1;
        case (idx)
          3'd0:    byte_c = SYNC0;
          3'd1:    byte_c = SYNC1;
          3'd2:    byte_c = {6'b0, len_q[17:16]};
          3'd3:    byte_c = len_q[15:8];
          default: byte_c = len_q[7:0];
        endcase
        if (sent) begin
          if (idx == 3'(HDR_LEN - 1)) begin
            idx_d   = 3'd0;
            state_d = ST_RD_ADDR;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      ST_RD_ADDR: begin
        wcnt_d  = 3'd0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wcnt == 3'(RD_WAIT - 1)) begin
          word_d  = s1_RD;
          idx_d   = 3'd0;
          state_d = ST_BYTE;
        end else begin
          wcnt_d = wcnt + 3'd1;
        end
      end
      ST_BYTE: begin
        send   = 1'b1;
        byte_c = word_byte(word_q, idx[1:0]);
        if (sent) begin
`ifdef DUMP_FRAMER_CHECKSUM_EN
          sum_d = sum + byte_c;
`endif
          if (idx == 3'(BYTES_PER_WORD - 1)) begin
            // Compare before incrementing so last_addr = 3FFFF ends cleanly.
            if (addr == len_q) begin
`ifdef DUMP_FRAMER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              addr_d  = addr + 1'b1;
              state_d = ST_RD_ADDR;
            end
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
`ifdef DUMP_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        send   = 1'b1;
        byte_c = ~sum;
        if (sent) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Outputs are derived from next-state values so
  // they change together with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      wcnt      <= 3'd0;
      len_q     <= '0;
      addr      <= '0;
      word_q    <= 32'h0;
      dump_done <= 1'b0;
      busy      <= 1'b0;
      s1_OE     <= 1'b1;
      s1_Addr   <= '0;
      rest      <= 16'h0;
`ifdef DUMP_FRAMER_CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      wcnt      <= wcnt_d;
      len_q     <= len_d;
      addr      <= addr_d;
      word_q    <= word_d;
      dump_done <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
      s1_OE     <= !((state_d == ST_RD_ADDR) || (state_d == ST_RD_WAIT));
      if (state_d == ST_RD_ADDR) s1_Addr <= addr_d;
      rest      <= (state_d == ST_IDLE) ? 16'h0 : 16'((len_d - addr_d) >> 2);
`ifdef DUMP_FRAMER_CHECKSUM_EN
      sum       <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_dump_framer.sv
// tb_dump_framer
//   Self-checking bench for dump_framer with a transmitter model (busy for a
//   fixed number of cycles per byte) and a combinational SRAM model.
//   Follows DUMP_FRAMER_CHECKSUM_EN for the expected frame contents.
module tb_dump_framer;

  localparam int BYTE_CYC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dump_kick = 1'b0;
  logic        dump_done;
  logic [17:0] last_addr = 18'h0;
  logic        s1_OE;
  logic [17:0] s1_Addr;
  logic [31:0] s1_RD;
  logic        rs_tx_start;
  logic [7:0]  rs_tx_data;
  logic        rs_tx_status;
  logic [15:0] rest;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [17:0] addr_q[$];

  int          dbl_start = 0;
  int          unstable = 0;
  int          early_start = 0;
  int          done_cnt = 0;
  logic        model_busy = 1'b0;
  int          busy_cnt = 0;
  logic [7:0]  cap = 8'h00;
  logic        prev_start = 1'b0;
  logic        prev_oe = 1'b1;
  logic        hold_hi = 1'b0;
  logic        rd_mode = 1'b0;
  logic [31:0] rd_const = 32'h0;

  assign rs_tx_status = model_busy | hold_hi;
  assign s1_RD = s1_OE ? 32'hDEADBEEF
               : (rd_mode ? {s1_Addr[7:0] ^ 8'h5C, 6'b0, s1_Addr} : rd_const);

  always #5 clk = ~clk;

  dump_framer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dump_kick    (dump_kick),
    .dump_done    (dump_done),
    .last_addr    (last_addr),
    .s1_OE        (s1_OE),
    .s1_Addr      (s1_Addr),
    .s1_RD        (s1_RD),
    .rs_tx_start  (rs_tx_start),
    .rs_tx_data   (rs_tx_data),
    .rs_tx_status (rs_tx_status),
    .rest         (rest),
    .busy         (busy)
  );

  // Transmitter model and monitor: records launched bytes and SRAM addresses,
  // and counts handshake protocol violations.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
      prev_start <= 1'b0;
      prev_oe    <= 1'b1;
    end else begin
      prev_start <= rs_tx_start;
      prev_oe    <= s1_OE;
      if (prev_oe && !s1_OE) addr_q.push_back(s1_Addr);
      if (dump_done) done_cnt <= done_cnt + 1;
      if (rs_tx_start) begin
        if (prev_start) dbl_start <= dbl_start + 1;
        if (rs_tx_status) early_start <= early_start + 1;
        got_q.push_back(rs_tx_data);
        cap        <= rs_tx_data;
        model_busy <= 1'b1;
        busy_cnt   <= BYTE_CYC;
      end else if (model_busy) begin
        if (rs_tx_data !== cap) unstable <= unstable + 1;
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) model_busy <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [17:0] a);
    return rd_mode ? {a[7:0] ^ 8'h5C, 6'b0, a} : rd_const;
  endfunction

  task automatic build_expected(input logic [17:0] last);
    logic [7:0]  s;
    logic [31:0] w;
    exp_q.delete();
    got_q.delete();
    addr_q.delete();
    s = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back({6'b0, last[17:16]});
    exp_q.push_back(last[15:8]);
    exp_q.push_back(last[7:0]);
    for (int a = 0; a <= int'(last); a++) begin
      w = word_of(18'(a));
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[b*8 +: 8]);
        s = s + w[b*8 +: 8];
      end
    end
`ifdef DUMP_FRAMER_CHECKSUM_EN
    exp_q.push_back(~s);
`endif
  endtask

  task automatic kick(input logic [17:0] last);
    @(negedge clk);
    last_addr = last;
    dump_kick = 1'b1;
    @(negedge clk);
    dump_kick = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dump_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (dump_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_dump_done: got %b want 0", dump_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (s1_OE !== 1'b1) begin bad++; $display("[TB] FAIL reset_s1_OE: got %b want 1", s1_OE); end
    total++; if (s1_Addr !== 18'h0) begin bad++; $display("[TB] FAIL reset_s1_Addr: got %h want 0", s1_Addr); end
    total++; if (rs_tx_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_start: got %b want 0", rs_tx_start); end
    total++; if (rs_tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data: got %h want 00", rs_tx_data); end
    total++; if (rest !== 16'h0) begin bad++; $display("[TB] FAIL reset_rest: got %h want 0", rest); end
  endtask

  task automatic test_single_word();
    logic       ok;
    logic [7:0] g, e;
    int         d0;
    rd_mode  = 1'b0;
    rd_const = 32'h04030201;
    build_expected(18'd0);
    d0 = done_cnt;
    kick(18'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL kick_busy: got %b want 1", busy); end
    total++; if (rs_tx_start !== 1'b1) begin bad++; $display("[TB] FAIL kick_first_start: got %b want 1", rs_tx_start); end
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL single_done_timeout: got 0 want 1"); end
    @(negedge clk);
    total++; if (dump_done !== 1'b0) begin bad++; $display("[TB] FAIL single_done_width: got %b want 0", dump_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
    repeat (3) @(negedge clk);
`ifdef DUMP_FRAMER_CHECKSUM_EN
    total++; if (got_q.size() != 10) begin bad++; $display("[TB] FAIL single_len: got %0d want 10", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[got_q.size()-1] !== 8'hF5) begin bad++; $display("[TB] FAIL single_csum: got %h want F5", got_q[got_q.size()-1]); end
    end
`else
    total++; if (got_q.size() != 9) begin bad++; $display("[TB] FAIL single_len: got %0d want 9", got_q.size()); end
`endif
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL single_byte: got %h want %h", g, e); end
    end
    total++; if (done_cnt != d0 + 1) begin bad++; $display("[TB] FAIL single_done_count: got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_multi_word();
    logic       ok;
    logic [7:0] g, e;
    int         n;
    rd_mode = 1'b1;
    build_expected(18'd3);
    n = exp_q.size();
    kick(18'd3);
    wait_done(5000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL multi_done_timeout: got 0 want 1"); end
    total++; if (rest !== 16'h0) begin bad++; $display("[TB] FAIL multi_rest_end: got %h want 0", rest); end
    repeat (3) @(negedge clk);
    total++; if (got_q.size() != n) begin bad++; $display("[TB] FAIL multi_len: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL multi_byte: got %h want %h", g, e); end
    end
    total++; if (addr_q.size() != 4) begin bad++; $display("[TB] FAIL multi_addr_count: got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      total++; if (addr_q[i] !== 18'(i)) begin bad++; $display("[TB] FAIL multi_addr_seq: got %h want %h", addr_q[i], 18'(i)); end
    end
  endtask

  task automatic test_kick_ignored();
    logic       ok;
    logic [7:0] g, e;
    int         d0, n;
    rd_mode = 1'b1;
    build_expected(18'd9);
    n  = exp_q.size();
    d0 = done_cnt;
    kick(18'd9);
    total++; if (rest !== 16'd2) begin bad++; $display("[TB] FAIL ignored_rest_start: got %0d want 2", rest); end
    repeat (200) @(negedge clk);
    last_addr = 18'd5;
    dump_kick = 1'b1;
    @(negedge clk);
    dump_kick = 1'b0;
    wait_done(8000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL ignored_done_timeout: got 0 want 1"); end
    repeat (60) @(negedge clk);
    total++; if (got_q.size() != n) begin bad++; $display("[TB] FAIL ignored_len: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL ignored_byte: got %h want %h", g, e); end
    end
    total++; if (done_cnt != d0 + 1) begin bad++; $display("[TB] FAIL ignored_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (unstable != 0) begin bad++; $display("[TB] FAIL tx_data_stable: got %0d want 0", unstable); end
  endtask

  task automatic test_status_hold();
    logic       ok;
    logic [7:0] g, e;
    int         starts, n;
    rd_mode  = 1'b0;
    rd_const = 32'h11223344;
    build_expected(18'd0);
    n = exp_q.size();
    hold_hi = 1'b1;
    kick(18'd0);
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      if (rs_tx_start) starts++;
      @(negedge clk);
    end
    total++; if (starts != 0) begin bad++; $display("[TB] FAIL hold_no_start: got %0d want 0", starts); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL hold_busy: got %b want 1", busy); end
    hold_hi = 1'b0;
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL hold_done_timeout: got 0 want 1"); end
    repeat (3) @(negedge clk);
    total++; if (got_q.size() != n) begin bad++; $display("[TB] FAIL hold_len: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL hold_byte: got %h want %h", g, e); end
    end
    total++; if (early_start != 0) begin bad++; $display("[TB] FAIL start_while_busy: got %0d want 0", early_start); end
    total++; if (dbl_start != 0) begin bad++; $display("[TB] FAIL double_start: got %0d want 0", dbl_start); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int   d0;
    rd_mode = 1'b1;
    build_expected(18'd3);
    d0 = done_cnt;
    kick(18'd3);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (got_q.size() >= 7) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL midreset_reach_byte: got 0 want 1"); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (s1_OE !== 1'b1) begin bad++; $display("[TB] FAIL midreset_s1_OE: got %b want 1", s1_OE); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
    total++; if (rs_tx_start !== 1'b0) begin bad++; $display("[TB] FAIL midreset_tx_start: got %b want 0", rs_tx_start); end
    total++; if (rest !== 16'h0) begin bad++; $display("[TB] FAIL midreset_rest: got %h want 0", rest); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("[TB] FAIL midreset_no_done: got %0d want 0", done_cnt - d0); end
    total++; if (got_q.size() != 7) begin bad++; $display("[TB] FAIL midreset_no_more_bytes: got %0d want 7", got_q.size()); end
  endtask

  task automatic test_frame_length();
    logic       ok;
    logic [7:0] g, e;
    rd_mode = 1'b1;
    build_expected(18'd1);
    kick(18'd1);
    wait_done(5000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL length_done_timeout: got 0 want 1"); end
    repeat (3) @(negedge clk);
`ifdef DUMP_FRAMER_CHECKSUM_EN
    total++; if (got_q.size() != 14) begin bad++; $display("[TB] FAIL length_count: got %0d want 14", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[got_q.size()-1] !== 8'h45) begin bad++; $display("[TB] FAIL length_last: got %h want 45", got_q[got_q.size()-1]); end
    end
`else
    total++; if (got_q.size() != 13) begin bad++; $display("[TB] FAIL length_count: got %0d want 13", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[got_q.size()-1] !== 8'h5D) begin bad++; $display("[TB] FAIL length_last: got %h want 5D", got_q[got_q.size()-1]); end
    end
`endif
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("[TB] FAIL length_byte: got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_kick_ignored();
    test_status_hold();
    test_reset_mid();
    test_frame_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
